// File: rtl/dbus_timer_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_timer_slave_if
//  Description : DBus request/response signal bundle shared by the CPU data
//                bus master and the responders on the fabric.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dbus_timer_slave_if;
  logic [29:0] address;
  logic [3:0]  byte_en;
  logic        read;
  logic        write;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        wait_request;

  modport master (
    output address, byte_en, read, write, write_data,
    input  read_data, wait_request
  );

  modport slave (
    input  address, byte_en, read, write, write_data,
    output read_data, wait_request
  );
endinterface
`default_nettype wire

// File: rtl/dbus_timer_slave.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_timer_slave
//  Description : DBus responder implementing a 64-bit machine timer (MTIME,
//                MTIMECMP, control, prescaler) with a level interrupt and a
//                programmable number of wait states per access.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbus_timer_slave #(
  parameter logic [29:0] P_BASE         = 30'h0400_0000,
  parameter int unsigned P_WAIT_STATES  = 0,
  parameter logic [15:0] P_PRESCALE_RST = 16'd0
) (
  input  wire logic         i_Clk,
  input  wire logic         i_Rst_n,
  dbus_timer_slave_if.slave dbus,
  output logic              o_Irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Counter load value: number of WAIT cycles minus one (unused with 0 ws).
  localparam logic [3:0] C_WS_LAST  = 4'(P_WAIT_STATES - 1);
  localparam bit         C_HAS_WAIT = (P_WAIT_STATES != 0);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_ws_cnt;
  logic [31:0] r_rdata;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [1:0]  r_ctrl;       // {IE, EN}
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic        r_irq;

  logic        w_sel;
  logic [2:0]  w_off;
  logic        w_commit;     // edge ending this cycle performs the access
  logic        w_load_ws;
  logic [31:0] w_rd_val;
  logic [31:0] w_merged;
  logic        w_wr_en;
  logic        w_wr_mlo, w_wr_mhi, w_wr_clo, w_wr_chi, w_wr_ctrl, w_wr_pre;
  logic        w_tick;

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode against the 8-word window.
  always_comb begin
    w_sel = (dbus.read | dbus.write) & (dbus.address[29:3] == P_BASE[29:3]);
    w_off = dbus.address[2:0];
  end

  // Current register value at the addressed offset; also the merge base for writes.
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      3'd0:    w_rd_val = r_mtime[31:0];
      3'd1:    w_rd_val = r_mtime[63:32];
      3'd2:    w_rd_val = r_mtimecmp[31:0];
      3'd3:    w_rd_val = r_mtimecmp[63:32];
      3'd4:    w_rd_val = {30'b0, r_ctrl};
      3'd5:    w_rd_val = {16'b0, r_prescale};
      default: w_rd_val = '0;
    endcase
  end

  // Access FSM next state; RESP can accept a new request directly.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_load_ws   = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_sel) begin
          if (C_HAS_WAIT) begin
            w_state_nxt = S_WAIT;
            w_load_ws   = 1'b1;
          end else begin
            w_state_nxt = S_RESP;
            w_commit    = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_ws_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_commit    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register and wait-state down-counter.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state  <= S_IDLE;
      r_ws_cnt <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_ws)
        r_ws_cnt <= C_WS_LAST;
      else if (r_state == S_WAIT && r_ws_cnt != 4'd0)
        r_ws_cnt <= r_ws_cnt - 4'd1;
    end
  end

  // Write strobes; read/write both high counts as a write.
  always_comb begin
    w_merged  = f_merge(w_rd_val, dbus.write_data, dbus.byte_en);
    w_wr_en   = w_commit & dbus.write;
    w_wr_mlo  = w_wr_en & (w_off == 3'd0);
    w_wr_mhi  = w_wr_en & (w_off == 3'd1);
    w_wr_clo  = w_wr_en & (w_off == 3'd2);
    w_wr_chi  = w_wr_en & (w_off == 3'd3);
    w_wr_ctrl = w_wr_en & (w_off == 3'd4);
    w_wr_pre  = w_wr_en & (w_off == 3'd5);
    w_tick    = r_ctrl[0] & (r_pcnt == r_prescale);
  end

  // Read data captured on the commit edge; writes return zero.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)
      r_rdata <= '0;
    else if (w_commit)
      r_rdata <= dbus.write ? 32'd0 : w_rd_val;
  end

  // Timer registers; an MTIME write drops any tick landing on the same edge.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_ctrl     <= 2'b00;
      r_prescale <= P_PRESCALE_RST;
      r_pcnt     <= '0;
    end else begin
      if (w_wr_mlo)
        r_mtime[31:0] <= w_merged;
      else if (w_wr_mhi)
        r_mtime[63:32] <= w_merged;
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;

      if (w_wr_clo) r_mtimecmp[31:0]  <= w_merged;
      if (w_wr_chi) r_mtimecmp[63:32] <= w_merged;
      if (w_wr_ctrl) r_ctrl <= w_merged[1:0];
      if (w_wr_pre)  r_prescale <= w_merged[15:0];

      if (w_wr_pre)
        r_pcnt <= '0;
      else if (r_ctrl[0])
        r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
    end
  end

  // Interrupt level from the registered compare, one cycle behind the timer.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)
      r_irq <= 1'b0;
    else
      r_irq <= r_ctrl[1] & (r_mtime >= r_mtimecmp);
  end

  assign dbus.wait_request = (r_state == S_WAIT);
  assign dbus.read_data    = (r_state == S_RESP) ? r_rdata : 32'd0;
  assign o_Irq             = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_dbus_timer_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbus_timer_slave
//  Description : Directed self-checking bench for dbus_timer_slave; one DUT
//                with zero wait states and one with two wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_timer_slave;

  localparam logic [29:0] BASE = 30'h0400_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq0, irq2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dbus_timer_slave_if bus0 ();
  dbus_timer_slave_if bus2 ();

  dbus_timer_slave #(.P_BASE(BASE), .P_WAIT_STATES(0), .P_PRESCALE_RST(16'd0)) dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .dbus(bus0), .o_Irq(irq0));

  dbus_timer_slave #(.P_BASE(BASE), .P_WAIT_STATES(2), .P_PRESCALE_RST(16'h0005)) dut2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .dbus(bus2), .o_Irq(irq2));

  task automatic drive(input int which, input logic rd, input logic wr, input logic [29:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    if (which == 0) begin
      bus0.read = rd; bus0.write = wr; bus0.address = addr; bus0.write_data = wd; bus0.byte_en = be;
    end else begin
      bus2.read = rd; bus2.write = wr; bus2.address = addr; bus2.write_data = wd; bus2.byte_en = be;
    end
  endtask

  function automatic logic get_wr(input int which);
    return (which == 0) ? bus0.wait_request : bus2.wait_request;
  endfunction

  function automatic logic [31:0] get_rd(input int which);
    return (which == 0) ? bus0.read_data : bus2.read_data;
  endfunction

  // Called at a negedge; returns at the negedge of the response cycle with the
  // bus released, so consecutive calls issue back-to-back requests.
  task automatic access(input int which, input logic wr, input logic [2:0] off, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int wcyc);
    bit done;
    done = 1'b0;
    wcyc = 0;
    rd   = '0;
    drive(which, !wr, wr, BASE + {27'd0, off}, wd, be);
    @(posedge clk);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (get_wr(which)) wcyc++;
      else begin
        rd   = get_rd(which);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout dut=%0d off=%0d still waiting after 20 cycles", which, off);
    end
    drive(which, 1'b0, 1'b0, '0, '0, 4'h0);
  endtask

  task automatic wr_reg(input int which, input logic [2:0] off, input logic [31:0] wd);
    logic [31:0] d; int w;
    access(which, 1'b1, off, wd, 4'hF, d, w);
  endtask

  task automatic test_reset();
    logic [31:0] d; int w;
    drive(0, 1'b0, 1'b0, '0, '0, 4'h0);
    drive(2, 1'b0, 1'b0, '0, '0, 4'h0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus0.wait_request, bus0.read_data, irq0, bus2.wait_request, bus2.read_data, irq2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wr0=%b rd0=%h irq0=%b wr2=%b rd2=%h irq2=%b exp all 0",
               bus0.wait_request, bus0.read_data, irq0, bus2.wait_request, bus2.read_data, irq2);
    end
    rst_n = 1'b1;
    access(2, 1'b0, 3'd3, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_mtimecmp_hi got %h exp ffffffff", d); end
    access(2, 1'b0, 3'd5, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'h0000_0005) begin errors++; $display("FAIL reset_prescale got %h exp 00000005", d); end
    // Asynchronous reset in the middle of a waited write aborts it.
    drive(2, 1'b0, 1'b1, BASE + 30'd4, 32'h3, 4'hF);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus2.wait_request !== 1'b1) begin errors++; $display("FAIL abort_waiting got %b exp 1", bus2.wait_request); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus2.wait_request, bus2.read_data, irq2} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs got wr=%b rd=%h irq=%b exp 0", bus2.wait_request, bus2.read_data, irq2);
    end
    drive(2, 1'b0, 1'b0, '0, '0, 4'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    access(2, 1'b0, 3'd4, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL abort_no_write got %h exp 00000000", d); end
  endtask

  task automatic test_wait_states();
    logic [31:0] d; int w;
    drive(2, 1'b1, 1'b0, BASE + 30'd4, '0, 4'hF);
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus2.wait_request !== (c < 3) || bus2.read_data !== 32'h0) begin
        errors++;
        $display("FAIL ws_cycle%0d got wr=%b rd=%h exp wr=%b rd=00000000", c, bus2.wait_request,
                 bus2.read_data, (c < 3));
      end
    end
    drive(2, 1'b0, 1'b0, '0, '0, 4'h0);
    access(2, 1'b1, 3'd4, 32'h3, 4'hF, d, w);
    checks++;
    if (w !== 2) begin errors++; $display("FAIL ws_write_waits got %0d exp 2", w); end
    access(2, 1'b0, 3'd4, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'h3 || w !== 2) begin errors++; $display("FAIL ws_read_ctrl got %h/%0d exp 00000003/2", d, w); end
  endtask

  task automatic test_byte_en();
    logic [31:0] d; int w;
    access(0, 1'b1, 3'd2, 32'hAABB_CCDD, 4'b0101, d, w);
    access(0, 1'b0, 3'd2, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'hFFBB_FFDD) begin errors++; $display("FAIL byte_en_merge got %h exp ffbbffdd", d); end
    access(0, 1'b1, 3'd2, 32'h0, 4'b0000, d, w);
    access(0, 1'b0, 3'd2, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'hFFBB_FFDD) begin errors++; $display("FAIL byte_en_none got %h exp ffbbffdd", d); end
    wr_reg(0, 3'd5, 32'hFFFF_1234);
    access(0, 1'b0, 3'd5, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'h0000_1234) begin errors++; $display("FAIL prescale_upper got %h exp 00001234", d); end
    wr_reg(0, 3'd4, 32'hFFFF_FFFE);
    access(0, 1'b0, 3'd4, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'h0000_0002) begin errors++; $display("FAIL ctrl_mask got %h exp 00000002", d); end
    wr_reg(0, 3'd6, 32'hDEAD_BEEF);
    access(0, 1'b0, 3'd6, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reserved_off6 got %h exp 00000000", d); end
  endtask

  task automatic test_counting();
    logic [31:0] d; int w;
    logic [31:0] exp_seq [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
    wr_reg(0, 3'd4, 32'h0);
    wr_reg(0, 3'd5, 32'd3);
    wr_reg(0, 3'd0, 32'h0);
    wr_reg(0, 3'd1, 32'h0);
    wr_reg(0, 3'd4, 32'h1);
    for (int i = 0; i < 9; i++) begin
      access(0, 1'b0, 3'd0, '0, 4'hF, d, w);
      checks++;
      if (d !== exp_seq[i]) begin errors++; $display("FAIL prescale3_read%0d got %h exp %h", i, d, exp_seq[i]); end
    end
    // Single tick across the lo->hi carry.
    wr_reg(0, 3'd4, 32'h0);
    wr_reg(0, 3'd5, 32'h0);
    wr_reg(0, 3'd0, 32'hFFFF_FFFF);
    wr_reg(0, 3'd1, 32'h0);
    wr_reg(0, 3'd4, 32'h1);
    wr_reg(0, 3'd4, 32'h0);
    access(0, 1'b0, 3'd0, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL carry_lo got %h exp 00000000", d); end
    access(0, 1'b0, 3'd1, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL carry_hi got %h exp 00000001", d); end
    // Single tick from all ones wraps to zero.
    wr_reg(0, 3'd0, 32'hFFFF_FFFF);
    wr_reg(0, 3'd1, 32'hFFFF_FFFF);
    wr_reg(0, 3'd4, 32'h1);
    wr_reg(0, 3'd4, 32'h0);
    access(0, 1'b0, 3'd0, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL wrap_lo got %h exp 00000000", d); end
    access(0, 1'b0, 3'd1, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL wrap_hi got %h exp 00000000", d); end
  endtask

  task automatic test_irq();
    wr_reg(0, 3'd4, 32'h0);
    wr_reg(0, 3'd5, 32'h0);
    wr_reg(0, 3'd3, 32'h0);
    wr_reg(0, 3'd2, 32'd10);
    wr_reg(0, 3'd0, 32'h0);
    wr_reg(0, 3'd1, 32'h0);
    wr_reg(0, 3'd4, 32'h3);
    // MTIME shows k after the k-th edge; the interrupt follows one edge later.
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (irq0 !== (k >= 11)) begin errors++; $display("FAIL irq_edge%0d got %b exp %b", k, irq0, (k >= 11)); end
    end
    wr_reg(0, 3'd2, 32'd100);
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq0); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_cmp_raise got %b exp 0", irq0); end
    wr_reg(0, 3'd2, 32'd5);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_cmp_lower got %b exp 1", irq0); end
    wr_reg(0, 3'd4, 32'h1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_ie_mask got %b exp 0", irq0); end
  endtask

  task automatic test_collision();
    logic [31:0] d; int w;
    // Counting every cycle (EN=1, PRESCALE=0) so the write lands on a tick edge.
    wr_reg(0, 3'd0, 32'd5);
    access(0, 1'b0, 3'd0, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL collision_write_wins got %h exp 00000005", d); end
    access(0, 1'b0, 3'd0, '0, 4'hF, d, w);
    checks++;
    if (d !== 32'd6) begin errors++; $display("FAIL collision_resume got %h exp 00000006", d); end
  endtask

  task automatic test_decode();
    drive(0, 1'b1, 1'b0, BASE + 30'd8, '0, 4'hF);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus0.wait_request !== 1'b0 || bus0.read_data !== 32'h0) begin
        errors++;
        $display("FAIL decode_outside%0d got wr=%b rd=%h exp wr=0 rd=00000000", c, bus0.wait_request, bus0.read_data);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0, 4'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1; int w0, w1;
    wr_reg(0, 3'd4, 32'h0);
    wr_reg(0, 3'd0, 32'h1111_1111);
    wr_reg(0, 3'd1, 32'h2222_2222);
    access(0, 1'b0, 3'd0, '0, 4'hF, d0, w0);
    access(0, 1'b0, 3'd1, '0, 4'hF, d1, w1);
    checks++;
    if (d0 !== 32'h1111_1111 || w0 !== 0) begin errors++; $display("FAIL b2b_first got %h/%0d exp 11111111/0", d0, w0); end
    checks++;
    if (d1 !== 32'h2222_2222 || w1 !== 0) begin errors++; $display("FAIL b2b_second got %h/%0d exp 22222222/0", d1, w1); end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_byte_en();
    test_counting();
    test_irq();
    test_collision();
    test_decode();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
